// File: rtl/opmem_pkg.sv
// opmem_pkg: shared FSM state type, widths and masked-merge helper for the opmem responder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package opmem_pkg;

  localparam int WORD_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_LD = 2'd1,
    BUSY_ST = 2'd2
  } state_t;

  // Bit-granular merge: mask bits set take the new data, clear keep the old word.
  function automatic logic [WORD_W-1:0] masked_merge(input logic [WORD_W-1:0] old_w,
                                                     input logic [WORD_W-1:0] new_w,
                                                     input logic [WORD_W-1:0] mask_w);
    return (old_w & ~mask_w) | (new_w & mask_w);
  endfunction

endpackage

// File: rtl/opmem_sram_array.sv
// opmem_sram_array: DEPTH x 64 storage, one registered read port and one bit-masked write port.
// Latency: read data registered one edge after rd_en; write lands at the edge ending wr_en.
// Backpressure: none; caller never issues read and write in the same cycle.
module opmem_sram_array
  import opmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [WORD_W-1:0] wr_mask_i
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Read register: cleared by reset, otherwise only loaded on a read, held in between.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem[rd_addr_i];
    end
  end

  // Masked read-modify-write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= masked_merge(mem[wr_addr_i], wr_data_i, wr_mask_i);
    end
  end

  assign rd_data_o = rdata_q;

endmodule

// File: rtl/opmem_responder.sv
// opmem_responder: word-indexed load/store responder over an internal 64-bit array (optional OPMEM_RANDOM_STALL_EN).
// Latency: done pulses LATENCY cycles after fire (LATENCY..LATENCY+3 with OPMEM_RANDOM_STALL_EN).
// Backpressure: one request in flight; both readies low while busy, store wins a same-cycle tie.
module opmem_responder
  import opmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              opload_index_valid,
  output logic              opload_index_ready,
  input  logic [WORD_W-1:0] opload_index,
  output logic              opload_operation_done,
  output logic [WORD_W-1:0] opload_read_data,
  input  logic              opstore_index_valid,
  output logic              opstore_index_ready,
  input  logic [WORD_W-1:0] opstore_index,
  input  logic [WORD_W-1:0] opstore_write_data,
  input  logic [WORD_W-1:0] opstore_write_mask,
  output logic              opstore_operation_done
);

  localparam int AW = $clog2(DEPTH);
`ifdef OPMEM_RANDOM_STALL_EN
  // One extra bit so LATENCY-1 plus up to 3 stall cycles never wraps.
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_init;
  logic              ld_done_q;
  logic              st_done_q;
  logic [AW-1:0]     st_addr_q;
  logic [WORD_W-1:0] st_data_q;
  logic [WORD_W-1:0] st_mask_q;
  logic              idle;
  logic              ld_fire;
  logic              st_fire;

  assign idle                = (state_q == IDLE);
  assign opstore_index_ready = idle & ~reset;
  assign opload_index_ready  = idle & ~reset & ~opstore_index_valid;
  assign st_fire             = opstore_index_valid & opstore_index_ready;
  assign ld_fire             = opload_index_valid & opload_index_ready;

`ifdef OPMEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR; its low two bits stretch each request.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign cnt_init = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
  assign cnt_init = CW'(LATENCY - 1);
`endif

  // FSM: done flags are registered so they are high exactly while BUSY_x has cnt==0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (st_fire) begin
            state_q   <= BUSY_ST;
            cnt_q     <= cnt_init;
            st_addr_q <= opstore_index[AW-1:0];
            st_data_q <= opstore_write_data;
            st_mask_q <= opstore_write_mask;
            st_done_q <= (cnt_init == '0);
          end else if (ld_fire) begin
            state_q   <= BUSY_LD;
            cnt_q     <= cnt_init;
            ld_done_q <= (cnt_init == '0);
          end
        end
        BUSY_LD, BUSY_ST: begin
          if (cnt_q != '0) begin
            cnt_q     <= cnt_q - CW'(1);
            ld_done_q <= (state_q == BUSY_LD) && (cnt_q == CW'(1));
            st_done_q <= (state_q == BUSY_ST) && (cnt_q == CW'(1));
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The store commits in its done cycle, before ready can reopen for a following load.
  opmem_sram_array #(.DEPTH(DEPTH)) u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_en_i   (ld_fire),
    .rd_addr_i (opload_index[AW-1:0]),
    .rd_data_o (opload_read_data),
    .wr_en_i   (st_done_q),
    .wr_addr_i (st_addr_q),
    .wr_data_i (st_data_q),
    .wr_mask_i (st_mask_q)
  );

  assign opload_operation_done  = ld_done_q;
  assign opstore_operation_done = st_done_q;

  // Index bits above the array size wrap by design.
  logic unused_index_hi;
  assign unused_index_hi = ^{opload_index[WORD_W-1:AW], opstore_index[WORD_W-1:AW]};

endmodule
